// File: rtl/scs8hd_arb_pkg.sv
// Shared definitions for the scs8hd 4-way arbiters: requester count, FSM
// encoding and release-cause bit positions.
package scs8hd_arb_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_e;

  // Bit positions in the release-cause vector.
  localparam int CAUSE_DONE = 0;
  localparam int CAUSE_DROP = 1;
  localparam int CAUSE_HOLD = 2;
  localparam int NCAUSE     = 3;

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/scs8hd_rrpick4.sv
// Combinational round-robin pick: the first set request bit scanning
// ptr, ptr+1, ... mod 4, as a one-hot vector and its index.
module scs8hd_rrpick4
  import scs8hd_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] pick,
  output logic [1:0]      pick_id
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    pick    = '0;
    pick_id = 2'd0;
    idx     = 2'd0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick_id   = idx;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scs8hd_rrarb4.sv
// 4-way round-robin arbiter: registered one-hot grant held until DONE, a
// request drop or the hold limit, then one grant-free gap cycle.
module scs8hd_rrarb4
  import scs8hd_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
`ifdef SC_USE_PG_PIN
  input  logic       vpwr,
  input  logic       vgnd,
  input  logic       vpb,
  input  logic       vnb,
`endif
  input  logic       CLK,
  input  logic       RESETB,
  input  logic [3:0] REQ,
  input  logic       DONE,
  output logic [3:0] GNT,
  output logic       GNT_VLD,
  output logic [1:0] GNT_ID,
  output logic       TIMEOUT
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr, vpb;
  supply0 vgnd, vnb;
`endif

  if (MAX_HOLD < 1 || MAX_HOLD > 256 || (2 ** CNT_W) < MAX_HOLD) begin : g_bad_param
    $error("scs8hd_rrarb4: illegal MAX_HOLD/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // Loss of any supply rail holds the block in reset.
  logic pg_ok;
  logic rst_n;
  assign pg_ok = vpwr & vpb & ~vgnd & ~vnb;
  assign rst_n = RESETB & pg_ok;

  arb_state_e        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        id_q, id_d;
  logic              timeout_q, timeout_d;
  logic [NCAUSE-1:0] cause;
  logic [3:0]        pick;
  logic [1:0]        pick_id;

  scs8hd_rrpick4 u_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_id (pick_id)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    timeout_d = 1'b0;

    cause             = '0;
    cause[CAUSE_DONE] = DONE;
    cause[CAUSE_DROP] = ~REQ[id_q];
    cause[CAUSE_HOLD] = (cnt_q == HOLD_LAST);

    case (state_q)
      // The gap arbitrates exactly like idle, using the pointer updated at release.
      IDLE, GAP: begin
        gnt_d = '0;
        if (|REQ) begin
          state_d = GRANT;
          gnt_d   = pick;
          id_d    = pick_id;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (|cause) begin
          state_d   = GAP;
          gnt_d     = '0;
          ptr_d     = wrap_inc(id_q);
          timeout_d = (cause == NCAUSE'(1 << CAUSE_HOLD));
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      gnt_q     <= 4'b0000;
      id_q      <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
    end
  end

  assign GNT     = gnt_q;
  assign GNT_VLD = |gnt_q;
  assign GNT_ID  = id_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: doc/scs8hd_rrarb4.md
Name: scs8hd_rrarb4

Overview:
- 4-way round-robin arbiter with grant-hold handshake.
- Shares one downstream resource among four requesters. Example: a shared NAND-reduced enable or one bus path into a cell cluster.
- Grants are one-hot and registered, with a forced one-cycle break-before-make gap between owners.
- An optional hold-limit timeout stops any requester from monopolising the resource.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner before forced release. Legal range 1..256.
- CNT_W, 8, hold-counter width. Must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- CLK  input  1  rising-edge clock.
- RESETB  input  1  asynchronous active-low reset.
- REQ  input  4  request per requester, active-high, level-sensitive.
- DONE  input  1  current owner releases the resource. Sampled only while GNT_VLD=1.
- GNT  output  4  one-hot grant, registered.
- GNT_VLD  output  1  high when any GNT bit is high.
- GNT_ID  output  2  encoded index of the current owner. Holds the last owner when GNT_VLD=0.
- TIMEOUT  output  1  one-cycle pulse in the gap cycle following a hold-limit release.
- vpwr, vgnd, vpb, vnb  input  1 each  power/ground/bulk pins, present only when SC_USE_PG_PIN is defined. Otherwise supply1/supply0 internally.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RESETB): all state clears immediately on RESETB=0, with no clock edge required.
- Reset values:
  - GNT=0000, GNT_VLD=0, GNT_ID=00, TIMEOUT=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- State machine states: IDLE, GRANT, GAP.
- IDLE:
  - If REQ != 0, the next edge grants the first set bit scanning ptr, ptr+1, … cyclically (mod 4).
  - Latency is 1 cycle from REQ sampled to GNT high. Counter loads 0.
  - REQ=0 keeps the block in IDLE.
- GRANT, owner id:
  - The counter increments each cycle, saturating.
  - Release condition R = DONE | ~REQ[id] | (cnt == MAX_HOLD-1).
  - R=1: next edge clears GNT and GNT_VLD, sets ptr = id+1 mod 4, and enters GAP.
  - R=0: the grant holds unchanged.
  - Other REQ bits changing during GRANT have no effect.
- GAP:
  - Lasts exactly one cycle with GNT=0.
  - TIMEOUT=1 in this cycle only if the release cause was the hold limit alone (DONE=0 and REQ[id]=1 at the release edge). A simultaneous DONE or request drop gives TIMEOUT=0.
  - Arbitration runs in GAP with the updated ptr. If REQ != 0, the next edge goes straight to GRANT; otherwise to IDLE.
  - Result: exactly one grant-free cycle between back-to-back owners.
- MAX_HOLD=1: every grant lasts one cycle. Each release is a timeout unless DONE or a request drop coincides.
- A lone requester is re-granted after each gap, with ptr wrapping past it and back.
- GNT is never more than one-hot. GNT_VLD equals |GNT.
- RESETB deassertion is synchronised externally. The block assumes RESETB rises away from the CLK edge.

Decomposition:
- Package scs8hd_arb_pkg holds:
  - NREQ=4 constant.
  - State encoding IDLE=2'b00, GRANT=2'b01, GAP=2'b10.
  - Release-cause constants (DONE, DROP, HOLD).
- One combinational sub-module, scs8hd_rrpick4: inputs REQ[3:0] and ptr[1:0], outputs a one-hot pick and its 2-bit index. Instantiated once. Reused by future 4-way arbiters.

Test Plan:
- Reset check: RESETB=0 for 3 cycles with REQ=1111, then mid-cycle release → GNT=0000, GNT_VLD=0, GNT_ID=00, TIMEOUT=0 throughout reset. First grant is GNT=0001 one edge after release.
- Single grant and DONE release: REQ=0100 at edge 0 → GNT=0100, GNT_ID=10 from edge 1. DONE=1 sampled at edge 4 → GNT=0000 at edge 5 (TIMEOUT=0). Following REQ=1111 grants requester 3 (ptr=3).
- Fairness: REQ=1111 held, DONE asserted in the 2nd cycle of each grant → grant order 0,1,2,3,0. Each grant lasts 2 cycles, separated by exactly one GNT=0000 cycle.
- Timeout and lone requester: MAX_HOLD=8, REQ=0001 held, DONE=0 → GNT=0001 for 8 cycles, then one gap cycle with TIMEOUT=1, then GNT=0001 again. Repeats periodically with period 9.
- Simultaneous events: DONE=1 on the same edge the counter hits MAX_HOLD-1 → release occurs with TIMEOUT=0. With MAX_HOLD=1 and REQ=0011, DONE=0 → alternating grants 0,1 with TIMEOUT=1 in every gap.
- Reset mid-operation: RESETB driven low between edges while GNT=0010 → GNT=0000 immediately, with no CLK edge. After release with REQ=0110, the grant goes to requester 1 (ptr reset to 0).
